board_row_reader: RTL and testbench
===================================

// Module: board_row_reader
// PURPOSE
//  Read side of the 256-bit board register. Snapshots the live board once per frame and
//  streams it row by row (row 0..ROWS-1) to a downstream display driver over a valid/ready handshake.
//  Optionally blinks (inverts) the row currently selected for editing so the user can see the cursor.
//  Sits between the board register/set-up path and the LED/display output logic.
// PARAMETERS
//  ROWS         16      rows per board; row r occupies board bits [r*COLS +: COLS]
//  COLS         16      cells per row; width of row_data
//  TICK_DIV     100000  clk cycles between row starts (>=2)
//  BLINK_FRAMES 32      completed frames per cursor blink half-period (>=1)
// PORTS
//  clk           in   1          system clock, all logic on rising edge
//  reset         in   1          asynchronous, active-low reset
//  enable        in   1          1 = scan; 0 = return to IDLE after any in-flight transfer
//  board_input   in   ROWS*COLS  live board contents
//  cursor_index  in   4          row currently being edited
//  show_cursor   in   1          1 = blink the cursor row
//  row_data      out  COLS       row payload, stable while row_valid=1
//  row_index     out  4          row number of row_data
//  row_valid     out  1          payload available
//  row_ready     in   1          downstream accepts when row_valid & row_ready on a clk edge
//  frame_done    out  1          1-cycle pulse on the cycle after last row's handshake
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, row_data=0, row_index=0, row_valid=0, frame_done=0,
//   tick counter=0, frame counter=0, blink_phase=0, snapshot=0. Takes effect mid-transfer; no completion.
//  FSM states: IDLE, WAIT_TICK, LOAD, PRESENT.
//   IDLE: row_index=0; enable=1 -> WAIT_TICK with tick counter cleared.
//   WAIT_TICK: counter increments each cycle; at TICK_DIV-1 -> LOAD, counter cleared.
//    enable=0 in WAIT_TICK -> IDLE immediately.
//   LOAD (1 cycle): if row_index==0, snapshot <= board_input (whole frame coherent; later board
//    changes not visible until next frame). row_data <= snapshot row (the fresh board_input row when
//    row_index==0), inverted if show_cursor & blink_phase & row_index==cursor_index. -> PRESENT.
//   PRESENT: row_valid=1; row_data/row_index held constant until handshake (never retracted,
//    even if enable drops). On handshake: row_valid<=0;
//    row_index<ROWS-1 -> row_index+1; row_index==ROWS-1 -> row_index<=0, frame_done<=1 next cycle,
//    frame counter++ (at BLINK_FRAMES-1 wraps to 0 and toggles blink_phase).
//    Then enable=1 -> WAIT_TICK, else -> IDLE (row_index forced to 0).
//  Latency: tick expiry -> row_valid high 2 cycles later (LOAD then PRESENT). Row period =
//   TICK_DIV + 1 + handshake wait cycles.
//  cursor_index >= ROWS: no row highlighted. show_cursor=0: never invert, blink_phase still runs.
//  blink_phase / frame counter not cleared by enable=0; only by reset.
//  frame_done only after row ROWS-1 accepted; abandoned frames (enable drop) emit no pulse.
//  Counter widths $clog2 of their limits; no overflow past limit.
// TESTING
//  T1 reset=0 mid-PRESENT with row_valid=1 -> all outputs 0 same cycle, IDLE after release.
//  T2 TICK_DIV=4, row_ready=1, board row r = 16'h0100+r -> rows 0..15 emitted in order
//   with data 0100..010F, 6 cycles apart, frame_done pulse once after row 15.
//  T3 row_ready held 0 for 10 cycles on row 3 -> row_valid, row_data, row_index stable all 10 cycles.
//  T4 board_input changed during row 5 of frame -> rows 6..15 show old values; next frame new values.
//  T5 BLINK_FRAMES=1, show_cursor=1, cursor_index=2, row 2=16'h00FF -> frames alternate
//   00FF / FF00 on row 2; other rows unchanged. cursor_index=15 -> last row blinks (wrap edge).
//  T6 enable=0 during PRESENT of row 7 -> row 7 held until accepted, then IDLE, row_index=0,
//   no frame_done; re-enable restarts at row 0.

Source files
------------

// File: rtl/board_row_if.sv
// board_row_if: row payload handshake between the board reader and the display driver.
interface board_row_if #(
  parameter int COLS = 16
) ();
  logic [COLS-1:0] row_data;
  logic [3:0] row_index;
  logic row_valid;
  logic row_ready;
  logic frame_done;
  modport master (output row_data, row_index, row_valid, frame_done, input row_ready);
  modport slave (input row_data, row_index, row_valid, frame_done, output row_ready);
endinterface

// File: rtl/board_row_reader.sv
// board_row_reader: snapshots the board once per frame and streams it row by row,
// optionally blinking the cursor row.
module board_row_reader #(
  parameter int ROWS = 16,
  parameter int COLS = 16,
  parameter int TICK_DIV = 100000,
  parameter int BLINK_FRAMES = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic [ROWS*COLS-1:0] board_input,
  input  logic [3:0] cursor_index,
  input  logic show_cursor,
  board_row_if.master row
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  typedef enum logic [1:0] {IDLE, WAIT_TICK, LOAD, PRESENT} state_t;
  state_t state, nxt;
  logic [TW-1:0] tick;
  logic [FW-1:0] frames;
  logic blink_phase;
  logic [ROWS*COLS-1:0] snapshot;
  logic tick_end, hs, last, hit;
  logic [COLS-1:0] src;
  assign tick_end = tick == TW'(TICK_DIV - 1);
  assign hs = state == PRESENT && row.row_ready;
  assign last = row.row_index == 4'(ROWS - 1);
  assign hit = show_cursor && blink_phase && row.row_index == cursor_index;
  // Row 0 reads the live board directly, since the snapshot is only being captured this cycle.
  assign src = row.row_index == '0 ? board_input[0 +: COLS] : snapshot[row.row_index*COLS +: COLS];
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (enable ? WAIT_TICK : IDLE) :
          state == WAIT_TICK ? (!enable ? IDLE : tick_end ? LOAD : WAIT_TICK) :
          state == LOAD ? PRESENT :
          hs ? (enable ? WAIT_TICK : IDLE) : PRESENT;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= nxt;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick <= '0;
      frames <= '0;
      blink_phase <= 1'b0;
      snapshot <= '0;
      row.row_data <= '0;
      row.row_index <= '0;
      row.row_valid <= 1'b0;
      row.frame_done <= 1'b0;
    end else begin
      tick <= state == WAIT_TICK && !tick_end ? tick + 1'b1 : '0;
      row.frame_done <= hs && last;
      if (state == LOAD) begin
        if (row.row_index == '0) snapshot <= board_input;
        row.row_data <= src ^ {COLS{hit}};
        row.row_valid <= 1'b1;
      end
      if (hs) row.row_valid <= 1'b0;
      if (hs && last) begin
        frames <= frames == FW'(BLINK_FRAMES - 1) ? '0 : frames + 1'b1;
        blink_phase <= frames == FW'(BLINK_FRAMES - 1) ? !blink_phase : blink_phase;
      end
      row.row_index <= nxt == IDLE ? '0 : hs ? (last ? '0 : row.row_index + 4'd1) : row.row_index;
    end
  end
endmodule

// File: tb/tb_board_row_reader.sv
// tb_board_row_reader: randomized and directed stimulus against a frame-level reference model.
module tb_board_row_reader;
  localparam int ROWS = 16, COLS = 16, TD = 4, BF = 2;
  logic clk = 1'b0, reset = 1'b0, enable = 1'b0, show_cursor = 1'b0;
  logic [ROWS*COLS-1:0] board = '0;
  logic [3:0] cursor = '0;
  int errors = 0, checks = 0, frames = 0;
  board_row_if #(.COLS(COLS)) bus ();
  board_row_reader #(.ROWS(ROWS), .COLS(COLS), .TICK_DIV(TD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .enable(enable), .board_input(board),
    .cursor_index(cursor), .show_cursor(show_cursor), .row(bus)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  logic [COLS-1:0] snap [ROWS];
  logic [COLS-1:0] exp_data;
  logic [ROWS*COLS-1:0] bd_prev;
  logic [3:0] cur_prev;
  logic phase, prev_valid, fd_exp, sc_prev, gap_armed;
  int fc, exp_idx, gap, vcnt, vprev;
  // Reference: a frame is a coherent copy of the board taken when row 0 is loaded;
  // the load cycle is the cycle just before row_valid rises.
  always @(negedge clk) begin
    if (!reset) begin
      phase = 0; fc = 0; exp_idx = 0; prev_valid = 0; fd_exp = 0; gap_armed = 0;
    end else begin
      check("frame_done", bus.frame_done, fd_exp);
      if (bus.frame_done) frames++;
      fd_exp = 0;
      gap++;
      if (bus.row_valid && !prev_valid) begin
        if (exp_idx == 0) for (int r = 0; r < ROWS; r++) snap[r] = bd_prev[r*COLS +: COLS];
        exp_data = snap[exp_idx] ^ {COLS{sc_prev && phase && cur_prev == 4'(exp_idx)}};
        if (gap_armed) check("row_gap", gap, TD + 1 + vprev);
        gap = 0; gap_armed = 1; vcnt = 0;
      end
      if (bus.row_valid) begin
        vcnt++;
        check("row_index", 32'(bus.row_index), exp_idx);
        check("row_data", 32'(bus.row_data), 32'(exp_data));
        if (bus.row_ready) begin
          if (exp_idx == ROWS - 1) begin
            fd_exp = 1;
            fc++;
            if (fc == BF) begin fc = 0; phase = !phase; end
          end
          exp_idx = (exp_idx == ROWS - 1 || !enable) ? 0 : exp_idx + 1;
          vprev = vcnt;
          if (!enable) gap_armed = 0;
        end
      end
      prev_valid = bus.row_valid;
    end
    bd_prev = board; sc_prev = show_cursor; cur_prev = cursor;
  end
  task automatic wait_frames(int n);
    int target = frames + n;
    int lim = 0;
    while (frames < target && lim < 5000) begin @(posedge clk); lim++; end
    check("frame_wait", frames >= target, 1);
  endtask
  task automatic wait_row(int idx);
    int lim = 0;
    do begin @(negedge clk); lim++; end
    while (!(bus.row_valid && bus.row_index == 4'(idx)) && lim < 2000);
    check("row_wait", lim < 2000, 1);
  endtask
  task automatic run_random(int n);
    int target = frames + n;
    int lim = 0;
    while (frames < target && lim < 20000) begin
      @(posedge clk); #1;
      lim++;
      bus.row_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 7) == 0) begin
        int k = $urandom_range(0, ROWS*COLS - 1);
        board[k] = ~board[k];
      end
      if ($urandom_range(0, 49) == 0) cursor = 4'($urandom);
      if ($urandom_range(0, 39) == 0) show_cursor = ~show_cursor;
    end
    check("random_wait", frames >= target, 1);
  endtask
  task automatic check_zero(string tag);
    check({tag, "_valid"}, bus.row_valid, 0);
    check({tag, "_index"}, 32'(bus.row_index), 0);
    check({tag, "_data"}, 32'(bus.row_data), 0);
    check({tag, "_fd"}, bus.frame_done, 0);
  endtask
  task automatic load_pattern();
    for (int r = 0; r < ROWS; r++) board[r*COLS +: COLS] = 16'(16'h0100 + r);
  endtask
  initial begin
    bus.row_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check_zero("reset");
    load_pattern();
    bus.row_ready = 1'b1;
    enable = 1'b1;
    wait_frames(2);
    wait_row(2);
    @(posedge clk); #1 bus.row_ready = 1'b0;
    wait_row(3);
    repeat (10) @(negedge clk);
    bus.row_ready = 1'b1;
    wait_row(5);
    @(posedge clk); #1 bus.row_ready = 1'b0;
    wait_row(6);
    #2 reset = 1'b0; enable = 1'b0;
    #1 check_zero("async_reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1; bus.row_ready = 1'b1;
    repeat (TD + 3) begin @(negedge clk); check("idle_valid", bus.row_valid, 0); end
    enable = 1'b1;
    wait_row(5);
    for (int r = 0; r < ROWS; r++) board[r*COLS +: COLS] = 16'($urandom);
    wait_frames(2);
    load_pattern();
    board[2*COLS +: COLS] = 16'h00FF;
    cursor = 4'd2;
    show_cursor = 1'b1;
    wait_frames(4);
    cursor = 4'd15;
    wait_frames(4);
    wait_row(7);
    enable = 1'b0; bus.row_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_valid", bus.row_valid, 1);
    bus.row_ready = 1'b1;
    begin
      int lim = 0;
      while (bus.row_valid && lim < 50) begin @(negedge clk); lim++; end
    end
    check("abandon_release", bus.row_valid, 0);
    check("abandon_index", 32'(bus.row_index), 0);
    repeat (10) begin @(negedge clk); check("abandon_idle", bus.row_valid, 0); end
    enable = 1'b1;
    wait_frames(1);
    run_random(6);
    bus.row_ready = 1'b1;
    repeat (20) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
